hazard_ctrl_unit: RTL



---
 rtl/hazard_ctrl_unit_pkg.sv | 38 +++
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_ctrl_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit: opcode values, PC source
// codes, CCR flag positions and FSM state encoding.
package hazard_ctrl_unit_pkg;

   // Opcode values; compared after casting to the configured opcode width
   localparam int unsigned OP_NOP = 0;
   localparam int unsigned OP_LDD = 1;
   localparam int unsigned OP_POP = 2;
   localparam int unsigned OP_JZ  = 3;
   localparam int unsigned OP_JN  = 4;
   localparam int unsigned OP_JC  = 5;
   localparam int unsigned OP_JMP = 6;
   localparam int unsigned OP_ADD = 7;
   localparam int unsigned OP_STD = 8;

   // CCR flag bit positions
   localparam int unsigned CCR_ZF = 0;
   localparam int unsigned CCR_CF = 1;
   localparam int unsigned CCR_NF = 3;

   typedef enum logic [1:0] {
      PC_SRC_NEXT = 2'b00,
      PC_SRC_REG  = 2'b01,
      PC_SRC_HOLD = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_FLUSH    = 2'b01,
      ST_MEM_WAIT = 2'b10
   } state_e;

   // True for opcodes whose result only exists after the memory stage
   function automatic logic is_load(input int unsigned op);
      return (op == OP_LDD) || (op == OP_POP);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count this cycle (ignored once all-ones)
//   clr      : zero on the next edge, overrides inc
//   cnt      : current count
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch-after-load stalls,
// taken-branch flushes with configurable length, memory-wait freeze with
// timeout abort, and saturating stall/flush counters.
//   ccr, opcode_d, src*_d, src*_vld_d   : decode-stage instruction and flags
//   opcode_e, dst_e, mem_rd_e           : D/E register contents
//   opcode_m, dst_m, mem_rd_m           : E/M register contents
//   mem_req_m, mem_ready                : memory handshake
//   cnt_clr                             : synchronous counter clear
//   pc_src, bubble, flush_fd, stall_all : pipeline control (combinational)
//   mem_timeout                         : one-cycle abort pulse
//   stall_cnt, flush_cnt                : performance counters
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int unsigned REG_AW       = 3,
   parameter int unsigned OP_W         = 5,
   parameter int unsigned CCR_W        = 4,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CCR_W-1:0]  ccr,
   input  logic [OP_W-1:0]   opcode_d,
   input  logic [REG_AW-1:0] src1_d,
   input  logic [REG_AW-1:0] src2_d,
   input  logic              src1_vld_d,
   input  logic              src2_vld_d,
   input  logic [OP_W-1:0]   opcode_e,
   input  logic [REG_AW-1:0] dst_e,
   input  logic              mem_rd_e,
   input  logic [OP_W-1:0]   opcode_m,
   input  logic [REG_AW-1:0] dst_m,
   input  logic              mem_rd_m,
   input  logic              mem_req_m,
   input  logic              mem_ready,
   input  logic              cnt_clr,
   output logic [1:0]        pc_src,
   output logic              bubble,
   output logic              flush_fd,
   output logic              stall_all,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned FL_W  = 2;
   localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d, ret_state_q, ret_state_d;
   logic [FL_W-1:0]   fl_cnt_q, fl_cnt_d, ret_fl_q, ret_fl_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              match_e, match_m, is_branch, taken, hz, mem_wait_req;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
   logic              unused_ccr;

   // Only sources the instruction really reads can create a hazard
   assign match_e = (src1_vld_d && (src1_d == dst_e)) || (src2_vld_d && (src2_d == dst_e));
   assign match_m = (src1_vld_d && (src1_d == dst_m)) || (src2_vld_d && (src2_d == dst_m));

   assign is_branch = (opcode_d == OP_W'(OP_JZ)) || (opcode_d == OP_W'(OP_JN)) ||
                      (opcode_d == OP_W'(OP_JC)) || (opcode_d == OP_W'(OP_JMP));
   assign taken     = (opcode_d == OP_W'(OP_JMP)) ||
                      ((opcode_d == OP_W'(OP_JZ)) && ccr[CCR_ZF]) ||
                      ((opcode_d == OP_W'(OP_JN)) && ccr[CCR_NF]) ||
                      ((opcode_d == OP_W'(OP_JC)) && ccr[CCR_CF]);

   assign hz = (is_load(32'(opcode_e)) && mem_rd_e && match_e) ||
               (is_branch && is_load(32'(opcode_m)) && mem_rd_m && match_m);

   assign mem_wait_req = mem_req_m && !mem_ready;
   assign unused_ccr   = ^ccr;

   // State and saved-return registers
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      fl_cnt_q    <= fl_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ret_state_q <= ret_state_d;
      ret_fl_q    <= ret_fl_d;
   end

   // Next-state and control outputs; reset path leaves all outputs at zero
   always_comb begin
      state_d     = state_q;
      fl_cnt_d    = fl_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      ret_state_d = ret_state_q;
      ret_fl_d    = ret_fl_q;
      pc_src      = PC_SRC_NEXT;
      bubble      = 1'b0;
      flush_fd    = 1'b0;
      stall_all   = 1'b0;
      mem_timeout = 1'b0;

      if (rst) begin
         state_d     = ST_RUN;
         fl_cnt_d    = '0;
         tmo_cnt_d   = '0;
         ret_state_d = ST_RUN;
         ret_fl_d    = '0;
      end else begin
         case (state_q)
            ST_MEM_WAIT: begin
               stall_all = 1'b1;
               pc_src    = PC_SRC_HOLD;
               if (mem_ready) begin
                  state_d  = ret_state_q;
                  fl_cnt_d = ret_fl_q;
               end else if (tmo_cnt_q == TMO_W'(MEM_TIMEOUT)) begin
                  // Abort drops any interrupted flush
                  mem_timeout = 1'b1;
                  state_d     = ST_RUN;
                  fl_cnt_d    = '0;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
            ST_RUN, ST_FLUSH: begin
               if (mem_wait_req) begin
                  stall_all   = 1'b1;
                  pc_src      = PC_SRC_HOLD;
                  ret_state_d = state_q;
                  ret_fl_d    = fl_cnt_q;
                  tmo_cnt_d   = TMO_W'(1);
                  state_d     = ST_MEM_WAIT;
               end else if (state_q == ST_FLUSH) begin
                  // Decode contents are stale here; no branch evaluation
                  flush_fd = 1'b1;
                  if (fl_cnt_q == FL_W'(1)) begin
                     state_d  = ST_RUN;
                     fl_cnt_d = '0;
                  end else begin
                     fl_cnt_d = fl_cnt_q - FL_W'(1);
                  end
               end else if (hz) begin
                  bubble = 1'b1;
                  pc_src = PC_SRC_HOLD;
               end else if (is_branch && taken) begin
                  pc_src   = PC_SRC_REG;
                  flush_fd = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d  = ST_FLUSH;
                     fl_cnt_d = FL_W'(FLUSH_CYCLES - 1);
                  end
               end
            end
            default: begin
               state_d  = ST_RUN;
               fl_cnt_d = '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bubble || stall_all),
      .clr (cnt_clr),
      .cnt (stall_cnt_q)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_fd),
      .clr (cnt_clr),
      .cnt (flush_cnt_q)
   );

   // Counter outputs read as zero while reset is held
   assign stall_cnt = rst ? '0 : stall_cnt_q;
   assign flush_cnt = rst ? '0 : flush_cnt_q;

endmodule
